// File: rtl/fma_pkg.sv
// Shared types for the FMA alignment stage: widths, select encodings,
// handshake state encoding and the aligned-result record.
package fma_pkg;

    localparam int MW = 50;
    localparam int EW = 8;

    localparam logic [1:0] SEL_P_BIG = 2'b00;
    localparam logic [1:0] SEL_C_BIG = 2'b01;
    localparam logic [1:0] SEL_EQ    = 2'b10;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL2 = 2'd2
    } state_e;

    typedef struct packed {
        logic [MW-1:0] al_P;
        logic [MW-1:0] al_C;
        logic [EW-1:0] exp_max;
        logic          sticky;
        logic [1:0]    sel;
    } align_res_t;

    localparam align_res_t RES_RST = '{
        al_P:    '0,
        al_C:    '0,
        exp_max: '0,
        sticky:  1'b0,
        sel:     SEL_EQ
    };

    // The reserved select code 11 behaves exactly like "equal exponents".
    function automatic logic [1:0] norm_sel(input logic [1:0] s);
        return (s == 2'b11) ? SEL_EQ : s;
    endfunction

endpackage

// File: rtl/fma_align_shifter.sv
// Combinational alignment: right-shifts the smaller-exponent mantissa by the
// exponent difference, saturating to zero at MW, and ORs the lost bits into
// a sticky flag.
module fma_align_shifter
    import fma_pkg::*;
(
    input  logic [1:0]    sel_in,
    input  logic [EW-1:0] sub_in,
    input  logic [MW-1:0] p_in,
    input  logic [MW-1:0] c_in,
    input  logic [EW-1:0] exp_p_in,
    input  logic [EW-1:0] exp_c_in,
    output align_res_t    res
);

    // Shift with saturation: any distance of MW or more empties the operand.
    function automatic logic [MW-1:0] shift_sat(input logic [MW-1:0] op,
                                                input logic [EW-1:0] sh);
        if (int'(sh) >= MW)
            return '0;
        return op >> sh;
    endfunction

    // Sticky: OR of the sh least-significant bits, the whole operand once sh >= MW.
    function automatic logic sticky_sat(input logic [MW-1:0] op,
                                        input logic [EW-1:0] sh);
        logic [MW-1:0] mask;
        if (int'(sh) >= MW)
            return |op;
        mask = ~({MW{1'b1}} << sh);
        return |(op & mask);
    endfunction

    // Pick the operand to shift from the select and build the aligned record.
    always_comb begin
        res         = RES_RST;
        res.al_P    = p_in;
        res.al_C    = c_in;
        res.exp_max = exp_p_in;
        res.sticky  = 1'b0;
        res.sel     = norm_sel(sel_in);
        case (norm_sel(sel_in))
            SEL_P_BIG: begin
                res.al_C   = shift_sat(c_in, sub_in);
                res.sticky = sticky_sat(c_in, sub_in);
            end
            SEL_C_BIG: begin
                res.al_P    = shift_sat(p_in, sub_in);
                res.sticky  = sticky_sat(p_in, sub_in);
                res.exp_max = exp_c_in;
            end
            default: begin
                res.sticky = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fma_align_stage.sv
// FMA stage four: aligns the stage-three mantissas and hands them to the adder
// through a valid/ready interface backed by a main register and a skid entry,
// so the adder can stall without losing beats.
module fma_align_stage
    import fma_pkg::*;
#(
    parameter int MW = fma_pkg::MW,
    parameter int EW = fma_pkg::EW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] sub_out_in,
    input  logic [1:0]    sub_en_in,
    input  logic [MW-1:0] out_P_in,
    input  logic [MW-1:0] out_C_in,
    input  logic [EW-1:0] exp_P_in,
    input  logic [EW-1:0] exp_C_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] al_P,
    output logic [MW-1:0] al_C,
    output logic [EW-1:0] exp_max,
    output logic          sticky_out,
    output logic [1:0]    sel_out
);

    state_e     state;
    state_e     state_nxt;
    align_res_t res_p0;
    align_res_t main_p1;
    align_res_t skid_p1;
    logic       vld_p1;
    logic       accept;
    logic       ld_main_new;
    logic       ld_main_skid;
    logic       ld_skid;

    // ---- p0: alignment of the incoming beat ----
    fma_align_shifter u_shifter (
        .sel_in   (sub_en_in),
        .sub_in   (sub_out_in),
        .p_in     (out_P_in),
        .c_in     (out_C_in),
        .exp_p_in (exp_P_in),
        .exp_c_in (exp_C_in),
        .res      (res_p0)
    );

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready = (state != FULL2);
    assign accept   = in_valid & in_ready;
    assign vld_p1   = (state != EMPTY);

    // Occupancy transitions and register load enables.
    always_comb begin
        state_nxt    = state;
        ld_main_new  = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    ld_main_new = 1'b1;
                    state_nxt   = ONE;
                end
            end
            ONE: begin
                if (accept && out_ready) begin
                    ld_main_new = 1'b1;
                end else if (accept) begin
                    ld_skid   = 1'b1;
                    state_nxt = FULL2;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            FULL2: begin
                if (out_ready) begin
                    ld_main_skid = 1'b1;
                    state_nxt    = ONE;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // Occupancy state; reset discards both entries at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // ---- p1: main (output) register and skid entry ----
    // Main register takes a fresh beat or the parked skid beat; otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            main_p1 <= RES_RST;
        else if (ld_main_new)
            main_p1 <= res_p0;
        else if (ld_main_skid)
            main_p1 <= skid_p1;
    end

    // Skid entry parks a beat that arrives while the main register is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            skid_p1 <= RES_RST;
        else if (ld_skid)
            skid_p1 <= res_p0;
    end

    assign out_valid  = vld_p1;
    assign al_P       = main_p1.al_P;
    assign al_C       = main_p1.al_C;
    assign exp_max    = main_p1.exp_max;
    assign sticky_out = main_p1.sticky;
    assign sel_out    = main_p1.sel;

endmodule
